// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types for the unified-memory arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef logic owner_t;

    localparam owner_t OWN_I = 1'b0;
    localparam owner_t OWN_D = 1'b1;

endpackage

// File: rtl/mem_arb_rr.sv
// rtl/mem_arb_rr.sv - two-way round-robin pick with last-grant memory
module mem_arb_rr
    import mem_arb_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   i_req,
    input  logic   d_req,
    input  logic   grant_en,
    output owner_t winner,
    output logic   any_req
);

    owner_t last_grant;

    // On a tie the side that was not served last wins; reset favours D first.
    always_comb begin
        any_req = i_req | d_req;
        winner  = (i_req && d_req) ? ~last_grant : owner_t'(d_req);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= OWN_I;
        end else if (grant_en && any_req) begin
            last_grant <= winner;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin I/D arbiter in front of one fixed-latency memory
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_valid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_valid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_enable,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out
);

    localparam int CNT_W = $clog2(MEM_LAT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    owner_t             owner_q;
    logic               wr_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [DATA_W-1:0]  rdata_q;
    owner_t             winner;
    logic               any_req;
    logic               grant_en;

    assign grant_en = (state == IDLE);

    mem_arb_rr u_rr (
        .clk      (clk),
        .rst      (rst),
        .i_req    (i_req),
        .d_req    (d_req),
        .grant_en (grant_en),
        .winner   (winner),
        .any_req  (any_req)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = BUSY;
            BUSY:    if (cnt == CNT_LAST) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The request is latched at grant so requester inputs may move during the access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            owner_q <= OWN_I;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner_q <= winner;
                        addr_q  <= (winner == OWN_D) ? d_addr : i_addr;
                        wr_q    <= (winner == OWN_D) && d_wr;
                        wdata_q <= (winner == OWN_D) ? d_wdata : '0;
                        cnt     <= '0;
                    end
                end
                BUSY: begin
                    if (cnt == CNT_LAST) begin
                        if (!wr_q) rdata_q <= mem_data_out;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        mem_enable  = 1'b0;
        mem_wr      = 1'b0;
        mem_addr    = '0;
        mem_data_in = '0;
        i_valid     = 1'b0;
        i_rdata     = '0;
        d_valid     = 1'b0;
        d_rdata     = '0;
        case (state)
            BUSY: begin
                mem_enable  = 1'b1;
                mem_wr      = wr_q && (cnt == '0);
                mem_addr    = addr_q;
                mem_data_in = wdata_q;
            end
            RESP: begin
                if (owner_q == OWN_D) begin
                    d_valid = 1'b1;
                    d_rdata = rdata_q;
                end else begin
                    i_valid = 1'b1;
                    i_rdata = rdata_q;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;

    localparam int L = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_req, d_req, d_wr;
    logic [15:0] i_addr, d_addr, d_wdata;
    logic        i_valid, d_valid, mem_enable, mem_wr;
    logic [15:0] i_rdata, d_rdata, mem_addr, mem_data_in, mem_data_out;

    logic        i_req1, d_req1, d_wr1;
    logic [15:0] i_addr1, d_addr1, d_wdata1;
    logic        i_valid1, d_valid1, mem1_enable, mem1_wr;
    logic [15:0] i_rdata1, d_rdata1, mem1_addr, mem1_data_in, mem1_data_out;

    logic [15:0] mem     [0:65535];
    logic [15:0] ref_mem [0:65535];
    int          en_cnt = -1;
    int          run = 0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    // Memory returns real data only in the MEM_LAT-th enabled cycle.
    assign mem_data_out  = (en_cnt == L - 1) ? mem[mem_addr] : 16'hDEAD;
    assign mem1_data_out = mem1_enable ? mem[mem1_addr] : 16'hDEAD;

    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(L)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_valid(i_valid), .i_rdata(i_rdata),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_valid(d_valid), .d_rdata(d_rdata),
        .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
    );

    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(1)) dut_lat1 (
        .clk(clk), .rst(rst),
        .i_req(i_req1), .i_addr(i_addr1), .i_valid(i_valid1), .i_rdata(i_rdata1),
        .d_req(d_req1), .d_wr(d_wr1), .d_addr(d_addr1), .d_wdata(d_wdata1),
        .d_valid(d_valid1), .d_rdata(d_rdata1),
        .mem_enable(mem1_enable), .mem_wr(mem1_wr), .mem_addr(mem1_addr),
        .mem_data_in(mem1_data_in), .mem_data_out(mem1_data_out)
    );

    function automatic logic [15:0] init_val(int a);
        if (a == 16'h0010) return 16'hA5A5;
        if (a == 16'h0030) return 16'hBEEF;
        return 16'(a) ^ 16'h5A5A;
    endfunction

    // Advance one cycle; afterwards we sit at the falling edge of the new cycle.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        if (mem_enable) begin
            en_cnt = run;
            run++;
            if (mem_wr) mem[mem_addr] = mem_data_in;
        end else begin
            en_cnt = -1;
            run = 0;
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        i_req = 0; i_addr = 0; d_req = 0; d_wr = 0; d_addr = 0; d_wdata = 0;
        i_req1 = 0; i_addr1 = 0; d_req1 = 0; d_wr1 = 0; d_addr1 = 0; d_wdata1 = 0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        rst = 1'b1;
        #1;
        checks++;
        if ({mem_enable, mem_wr, mem_addr, mem_data_in, i_valid, i_rdata, d_valid, d_rdata} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got en=%b wr=%b addr=%h din=%h iv=%b dv=%b, expected all 0",
                     mem_enable, mem_wr, mem_addr, mem_data_in, i_valid, d_valid);
        end
        checks++;
        if ({mem1_enable, mem1_wr, i_valid1, d_valid1, i_rdata1, d_rdata1} !== '0) begin
            errors++;
            $display("FAIL reset_outputs_lat1: got en=%b iv=%b dv=%b, expected 0", mem1_enable, i_valid1, d_valid1);
        end
        step();
        rst = 1'b0;
        step();
        checks++;
        if ({mem_enable, i_valid, d_valid} !== 3'b000) begin
            errors++;
            $display("FAIL idle_after_reset: got en/iv/dv=%b, expected 000", {mem_enable, i_valid, d_valid});
        end
    endtask

    task automatic test_single_read();
        apply_reset();
        i_req = 1; i_addr = 16'h0010;
        for (int c = 1; c <= 7; c++) begin
            step();
            checks++;
            if ({mem_enable, i_valid, d_valid} !== {c >= 1 && c <= L, c == L + 1, 1'b0}) begin
                errors++;
                $display("FAIL single_read cyc%0d: en/iv/dv=%b expected %b", c,
                         {mem_enable, i_valid, d_valid}, {c >= 1 && c <= L, c == L + 1, 1'b0});
            end
            if (mem_enable) begin
                checks++;
                if (mem_addr !== 16'h0010 || mem_wr !== 1'b0) begin
                    errors++;
                    $display("FAIL single_read_addr cyc%0d: addr=%h wr=%b expected 0010 0", c, mem_addr, mem_wr);
                end
            end
            if (c == L + 1) begin
                checks++;
                if (i_rdata !== 16'hA5A5) begin
                    errors++;
                    $display("FAIL single_read_data: got %h expected a5a5", i_rdata);
                end
                i_req = 0;
            end
        end
    endtask

    task automatic test_tie();
        apply_reset();
        i_req = 1; i_addr = 16'h0001;
        d_req = 1; d_wr = 0; d_addr = 16'h0002;
        for (int c = 1; c <= 12; c++) begin
            step();
            checks++;
            if ({i_valid, d_valid} !== {c == 11, c == 5}) begin
                errors++;
                $display("FAIL tie_order cyc%0d: iv/dv=%b expected %b", c, {i_valid, d_valid}, {c == 11, c == 5});
            end
            if (c == 5) begin
                checks++;
                if (d_rdata !== ref_mem[2]) begin
                    errors++;
                    $display("FAIL tie_d_data: got %h expected %h", d_rdata, ref_mem[2]);
                end
                d_req = 0;
            end
            if (c == 11) begin
                checks++;
                if (i_rdata !== ref_mem[1]) begin
                    errors++;
                    $display("FAIL tie_i_data: got %h expected %h", i_rdata, ref_mem[1]);
                end
                i_req = 0;
            end
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        i_req = 1; i_addr = 16'($urandom_range(0, 255));
        d_req = 1; d_wr = 0; d_addr = 16'($urandom_range(0, 255));
        for (int c = 1; c <= 48; c++) begin
            step();
            checks++;
            if ({i_valid, d_valid} !== {c % 12 == 11, c % 12 == 5}) begin
                errors++;
                $display("FAIL b2b_order cyc%0d: iv/dv=%b expected %b", c, {i_valid, d_valid},
                         {c % 12 == 11, c % 12 == 5});
            end
            if (c % 12 == 5) begin
                checks++;
                if (d_rdata !== ref_mem[d_addr]) begin
                    errors++;
                    $display("FAIL b2b_d_data cyc%0d: got %h expected %h", c, d_rdata, ref_mem[d_addr]);
                end
                d_addr = 16'($urandom_range(0, 255));
            end
            if (c % 12 == 11) begin
                checks++;
                if (i_rdata !== ref_mem[i_addr]) begin
                    errors++;
                    $display("FAIL b2b_i_data cyc%0d: got %h expected %h", c, i_rdata, ref_mem[i_addr]);
                end
                i_addr = 16'($urandom_range(0, 255));
            end
        end
        i_req = 0; d_req = 0;
    endtask

    task automatic test_store();
        apply_reset();
        d_req = 1; d_wr = 1; d_addr = 16'h0020; d_wdata = 16'h1234;
        for (int c = 1; c <= 6; c++) begin
            step();
            checks++;
            if ({mem_wr, d_valid, i_valid} !== {c == 1, c == 5, 1'b0}) begin
                errors++;
                $display("FAIL store_strobe cyc%0d: wr/dv/iv=%b expected %b", c, {mem_wr, d_valid, i_valid},
                         {c == 1, c == 5, 1'b0});
            end
            if (c == 1) begin
                checks++;
                if (mem_addr !== 16'h0020 || mem_data_in !== 16'h1234) begin
                    errors++;
                    $display("FAIL store_bus: addr=%h data=%h expected 0020 1234", mem_addr, mem_data_in);
                end
            end
            if (c == 5) begin
                d_req = 0;
                ref_mem[16'h0020] = 16'h1234;
            end
        end
        i_req = 1; i_addr = 16'h0020;
        for (int c = 1; c <= 5; c++) begin
            step();
            if (c == 5) begin
                checks++;
                if (i_valid !== 1'b1 || i_rdata !== 16'h1234) begin
                    errors++;
                    $display("FAIL store_readback: iv=%b data=%h expected 1 1234", i_valid, i_rdata);
                end
                i_req = 0;
            end
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        d_req = 1; d_wr = 0; d_addr = 16'h0044;
        step(); step(); step();
        rst = 1'b1;
        #1;
        checks++;
        if ({mem_enable, mem_wr, mem_addr, mem_data_in, i_valid, i_rdata, d_valid, d_rdata} !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs: en=%b addr=%h dv=%b expected all 0", mem_enable, mem_addr, d_valid);
        end
        d_req = 0;
        step(); step();
        rst = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            step();
            checks++;
            if ({d_valid, i_valid, mem_enable} !== 3'b000) begin
                errors++;
                $display("FAIL reset_mid_ghost cyc%0d: dv/iv/en=%b expected 000", c, {d_valid, i_valid, mem_enable});
            end
        end
        d_req = 1;
        for (int c = 1; c <= 5; c++) begin
            step();
            checks++;
            if ({mem_enable, d_valid} !== {c <= L, c == L + 1}) begin
                errors++;
                $display("FAIL reset_mid_retry cyc%0d: en/dv=%b expected %b", c, {mem_enable, d_valid},
                         {c <= L, c == L + 1});
            end
        end
        checks++;
        if (d_rdata !== ref_mem[16'h0044]) begin
            errors++;
            $display("FAIL reset_mid_data: got %h expected %h", d_rdata, ref_mem[16'h0044]);
        end
        d_req = 0;
    endtask

    task automatic test_lat1();
        apply_reset();
        i_req1 = 1; i_addr1 = 16'h0030;
        for (int c = 1; c <= 3; c++) begin
            step();
            checks++;
            if ({mem1_enable, i_valid1} !== {c == 1, c == 2}) begin
                errors++;
                $display("FAIL lat1_timing cyc%0d: en/iv=%b expected %b", c, {mem1_enable, i_valid1}, {c == 1, c == 2});
            end
            if (c == 2) begin
                checks++;
                if (i_rdata1 !== 16'hBEEF) begin
                    errors++;
                    $display("FAIL lat1_data: got %h expected beef", i_rdata1);
                end
                i_req1 = 0;
            end
        end
    endtask

    // Transaction-level model: a grant at the edge ending idle cycle c occupies
    // cycles c+1..c+L on the memory and responds in cycle c+L+1.
    task automatic test_random();
        int          start, icool, dcool;
        bit          active, t_own, t_wr, lg, ip, dp, busy, resp;
        logic [15:0] t_addr, t_data;
        apply_reset();
        start = -100; active = 0; lg = 0; ip = 0; dp = 0; icool = 0; dcool = 0;
        t_own = 0; t_wr = 0; t_addr = 0; t_data = 0;
        for (int c = 1; c <= 600; c++) begin
            step();
            busy = active && c >= start && c < start + L;
            resp = active && c == start + L;
            checks++;
            if (mem_enable !== busy || (busy && (mem_addr !== t_addr || mem_wr !== (t_wr && c == start)))) begin
                errors++;
                $display("FAIL rand_bus cyc%0d: en=%b addr=%h wr=%b expected %b %h %b", c, mem_enable, mem_addr,
                         mem_wr, busy, t_addr, t_wr && c == start);
            end
            if (busy && t_wr && c == start) begin
                checks++;
                if (mem_data_in !== t_data) begin
                    errors++;
                    $display("FAIL rand_wdata cyc%0d: got %h expected %h", c, mem_data_in, t_data);
                end
            end
            checks++;
            if ({i_valid, d_valid} !== {resp && !t_own, resp && t_own}) begin
                errors++;
                $display("FAIL rand_valid cyc%0d: iv/dv=%b expected %b", c, {i_valid, d_valid},
                         {resp && !t_own, resp && t_own});
            end
            if (resp && !t_wr) begin
                checks++;
                if ((t_own ? d_rdata : i_rdata) !== t_data) begin
                    errors++;
                    $display("FAIL rand_rdata cyc%0d: got %h expected %h", c, t_own ? d_rdata : i_rdata, t_data);
                end
            end
            checks++;
            if ((!i_valid && i_rdata !== 16'h0) || (!d_valid && d_rdata !== 16'h0)) begin
                errors++;
                $display("FAIL rand_idle_rdata cyc%0d: i=%h d=%h expected 0 when not valid", c, i_rdata, d_rdata);
            end
            if (resp) begin
                if (t_own) begin dp = 0; dcool = $urandom_range(0, 2); end
                else       begin ip = 0; icool = $urandom_range(0, 2); end
            end
            if (!ip) begin
                if (icool > 0) icool--;
                else if ($urandom_range(0, 1) == 1) begin ip = 1; i_addr = 16'($urandom_range(0, 15)); end
            end
            if (!dp) begin
                if (dcool > 0) dcool--;
                else if ($urandom_range(0, 1) == 1) begin
                    dp = 1; d_addr = 16'($urandom_range(0, 15));
                    d_wr = 1'($urandom_range(0, 1)); d_wdata = 16'($urandom);
                end
            end
            if (busy) begin
                if (t_own) begin d_addr = 16'($urandom); d_wdata = 16'($urandom); d_wr = 1'($urandom); end
                else       i_addr = 16'($urandom);
            end
            i_req = ip;
            d_req = dp;
            if ((!active || c > start + L) && (ip || dp)) begin
                t_own  = (ip && dp) ? ~lg : dp;
                lg     = t_own;
                active = 1;
                start  = c + 1;
                t_addr = t_own ? d_addr : i_addr;
                t_wr   = t_own && d_wr;
                if (t_wr) begin
                    t_data = d_wdata;
                    ref_mem[t_addr] = t_data;
                end else begin
                    t_data = ref_mem[t_addr];
                end
            end
        end
        i_req = 0; d_req = 0;
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) begin
            mem[a]     = init_val(a);
            ref_mem[a] = init_val(a);
        end
        test_reset();
        test_single_read();
        test_tie();
        test_back_to_back();
        test_store();
        test_reset_mid();
        test_lat1();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
